// File: rtl/uart_transmitter_if.sv
// Host-side bundle for the 8N1 UART transmitter: start request and byte in, serial line and busy out.
interface uart_transmitter_if;
  logic       transmit;
  logic [7:0] data;
  logic       serial_output_rx;
  logic       busy;

  modport master (
    output transmit,
    output data,
    input  serial_output_rx,
    input  busy
  );

  modport slave (
    input  transmit,
    input  data,
    output serial_output_rx,
    output busy
  );
endinterface

// File: rtl/uart_transmitter.sv
// 8N1 UART transmitter: start on transmit rising edge while idle, line low on the accepting edge, busy for 10*CLKS_PER_BIT cycles.
// No backpressure: start edges seen while busy are dropped, never queued.
module uart_transmitter #(
  parameter int CLKS_PER_BIT = 434,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                clk,
  input  logic                reset,
  uart_transmitter_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(CLKS_PER_BIT - 1);

  state_t               state, state_n;
  logic [CNT_WIDTH-1:0] cnt, cnt_n;
  logic [2:0]           idx, idx_n;
  logic [7:0]           shreg, shreg_n;
  logic                 transmit_d;
  logic                 line, line_n;
  logic                 busy_q, busy_n;
  logic                 start;
  logic                 bit_end;

  assign start   = bus.transmit && !transmit_d && (state == IDLE);
  assign bit_end = (cnt == CNT_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= '0;
      idx        <= '0;
      shreg      <= '0;
      transmit_d <= 1'b0;
      line       <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      idx        <= idx_n;
      shreg      <= shreg_n;
      transmit_d <= bus.transmit;
      line       <= line_n;
      busy_q     <= busy_n;
    end
  end

  // Outputs are computed for the next state so line/busy stay registered.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    shreg_n = shreg;
    line_n  = line;
    busy_n  = busy_q;
    case (state)
      IDLE: begin
        line_n = 1'b1;
        busy_n = 1'b0;
        cnt_n  = '0;
        idx_n  = '0;
        if (start) begin
          shreg_n = bus.data;
          state_n = START;
          line_n  = 1'b0;
          busy_n  = 1'b1;
        end
      end
      START: begin
        if (bit_end) begin
          cnt_n   = '0;
          idx_n   = '0;
          state_n = DATA;
          line_n  = shreg[0];
        end else begin
          cnt_n = cnt + CNT_WIDTH'(1);
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_n = '0;
          if (idx == 3'd7) begin
            state_n = STOP;
            line_n  = 1'b1;
          end else begin
            idx_n  = idx + 3'd1;
            line_n = shreg[idx_n];
          end
        end else begin
          cnt_n = cnt + CNT_WIDTH'(1);
        end
      end
      STOP: begin
        if (bit_end) begin
          cnt_n   = '0;
          state_n = IDLE;
          line_n  = 1'b1;
          busy_n  = 1'b0;
        end else begin
          cnt_n = cnt + CNT_WIDTH'(1);
        end
      end
      default: begin
        state_n = IDLE;
        line_n  = 1'b1;
        busy_n  = 1'b0;
      end
    endcase
  end

  assign bus.serial_output_rx = line;
  assign bus.busy             = busy_q;

endmodule

// File: tb/tb_uart_transmitter.sv
// Directed bench for uart_transmitter: bytes are queued when a start edge is driven and
// checked cycle by cycle against the serial line when the DUT raises busy.
module tb_uart_transmitter;
  localparam int CPB = 434;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;
  logic [7:0] exp_q[$];
  logic busy_prev = 1'b0;

  uart_transmitter_if ifc ();

  uart_transmitter #(.CLKS_PER_BIT(CPB), .CNT_WIDTH(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (ifc.busy !== 1'b0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", {31'd0, ifc.busy}, 32'd0);
  endtask

  task automatic wait_busy(input int budget);
    int n = 0;
    while (ifc.busy !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("busy_timeout", {31'd0, ifc.busy}, 32'd1);
  endtask

  // Frame monitor: each bit must hold its level for every one of its CPB cycles.
  initial begin
    logic [9:0] frame;
    logic [7:0] b8;
    int wrong;
    bit aborted;
    forever begin
      @(negedge clk);
      if (ifc.busy === 1'b1 && busy_prev !== 1'b1) begin
        total++;
        assert (exp_q.size() > 0) else begin
          bad++;
          $error("FAIL unexpected_frame observed=frame expected=none");
        end
        b8 = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        frame = {1'b1, b8, 1'b0};
        aborted = 1'b0;
        for (int b = 0; b < 10 && !aborted; b++) begin
          wrong = 0;
          for (int c = 0; c < CPB && !aborted; c++) begin
            if (b != 0 || c != 0) @(negedge clk);
            if (reset === 1'b0) aborted = 1'b1;
            else if (ifc.serial_output_rx !== frame[b] || ifc.busy !== 1'b1) wrong++;
          end
          if (!aborted) chk($sformatf("frame_%02h_bit%0d_bad_cycles", b8, b), wrong, 0);
        end
        if (!aborted) begin
          @(negedge clk);
          chk($sformatf("frame_%02h_busy_end", b8), {31'd0, ifc.busy}, 32'd0);
          chk($sformatf("frame_%02h_line_end", b8), {31'd0, ifc.serial_output_rx}, 32'd1);
        end
      end
      busy_prev = ifc.busy;
    end
  end

  initial begin
    reset        = 1'b0;
    ifc.transmit = 1'bx;
    ifc.data     = 8'hxx;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_line", {31'd0, ifc.serial_output_rx}, 32'd1);
      chk("rst_busy", {31'd0, ifc.busy}, 32'd0);
    end
    ifc.transmit = 1'b0;
    ifc.data     = 8'h00;
    reset        = 1'b1;
    tick(20);
    chk("post_rst_busy", {31'd0, ifc.busy}, 32'd0);
    chk("post_rst_line", {31'd0, ifc.serial_output_rx}, 32'd1);

    // Frame 1: 4-cycle pulse, data changes right after acceptance, retrigger mid-frame.
    ifc.transmit = 1'b1;
    ifc.data     = 8'h44;
    exp_q.push_back(8'h44);
    tick(1);
    ifc.data = 8'hFF;
    tick(3);
    ifc.transmit = 1'b0;
    tick(1000);
    ifc.transmit = 1'b1;
    ifc.data     = 8'h00;
    tick(2);
    ifc.transmit = 1'b0;
    wait_idle(10 * CPB);
    tick(200);
    chk("retrigger_ignored_busy", {31'd0, ifc.busy}, 32'd0);
    chk("retrigger_ignored_line", {31'd0, ifc.serial_output_rx}, 32'd1);

    // Frame 2 after a long idle gap, 2-cycle pulse.
    tick(2000);
    ifc.transmit = 1'b1;
    ifc.data     = 8'hA5;
    exp_q.push_back(8'hA5);
    tick(2);
    ifc.transmit = 1'b0;
    wait_idle(10 * CPB + 4);
    tick(5);

    // Frame 3 aborted by reset during data bit 3.
    ifc.transmit = 1'b1;
    ifc.data     = 8'h3C;
    exp_q.push_back(8'h3C);
    tick(1);
    ifc.transmit = 1'b0;
    tick(4 * CPB + 200);
    chk("pre_abort_busy", {31'd0, ifc.busy}, 32'd1);
    reset = 1'b0;
    #1;
    chk("abort_line", {31'd0, ifc.serial_output_rx}, 32'd1);
    chk("abort_busy", {31'd0, ifc.busy}, 32'd0);
    tick(3);
    reset = 1'b1;
    tick(30);
    chk("after_abort_busy", {31'd0, ifc.busy}, 32'd0);
    chk("after_abort_line", {31'd0, ifc.serial_output_rx}, 32'd1);

    // transmit held high across reset release is taken as a start edge.
    reset = 1'b0;
    tick(2);
    ifc.transmit = 1'b1;
    ifc.data     = 8'h5A;
    exp_q.push_back(8'h5A);
    reset = 1'b1;
    wait_busy(5);
    tick(3);
    ifc.transmit = 1'b0;
    wait_idle(10 * CPB + 4);
    tick(20);
    chk("queue_drained", exp_q.size(), 0);
    chk("final_line", {31'd0, ifc.serial_output_rx}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
